// File: rtl/bzmusic_pkg.sv
// -----------------------------------------------------------------------------
// bzmusic_pkg
//   Shared definitions for the buzzer music path.
//   - beat_state_t : note-duration timer states (IDLE / RUN / DONE)
//   - len_code_t   : 3-bit note length codes stored in the score ROM
//   - len_lut()    : maps a length code to its duration N in sixteenth notes
//   - DEF_*        : default timebase constants (50 MHz clock, 120 BPM),
//                    shared with the tune PWM block so both agree on the gap.
//   Optional feature macro used by the consumers: BZMUSIC_TRIPLET_EN.
// -----------------------------------------------------------------------------
package bzmusic_pkg;

  // Default timebase: 50 MHz / (120 BPM * 4 sixteenths per beat / 60 s).
  localparam int DEF_TICK_CYC      = 6_250_000;
  // Articulation gap at the end of every note (one tenth of a sixteenth).
  localparam int DEF_GAP_CYC       = 625_000;
  // Triplet sixteenth: two thirds of a straight sixteenth.
  localparam int DEF_TRIP_TICK_CYC = 4_166_667;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } beat_state_t;

  typedef enum logic [2:0] {
    LEN_16TH        = 3'd0,
    LEN_8TH         = 3'd1,
    LEN_QUARTER     = 3'd2,
    LEN_HALF        = 3'd3,
    LEN_WHOLE       = 3'd4,
    LEN_DOT_8TH     = 3'd5,
    LEN_DOT_QUARTER = 3'd6,
    LEN_DOT_HALF    = 3'd7
  } len_code_t;

  // Note duration in sixteenths. Largest value is 16, so five bits.
  function automatic logic [4:0] len_lut(input logic [2:0] code);
    len_lut = 5'd1;
    case (code)
      LEN_16TH:        len_lut = 5'd1;
      LEN_8TH:         len_lut = 5'd2;
      LEN_QUARTER:     len_lut = 5'd4;
      LEN_HALF:        len_lut = 5'd8;
      LEN_WHOLE:       len_lut = 5'd16;
      LEN_DOT_8TH:     len_lut = 5'd3;
      LEN_DOT_QUARTER: len_lut = 5'd6;
      LEN_DOT_HALF:    len_lut = 5'd12;
      default:         len_lut = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/bzmusic_tick_div.sv
// -----------------------------------------------------------------------------
// bzmusic_tick_div
//   Enable-gated prescaler that divides clk down to a sixteenth-note tick.
//   The wrap value is an input so the parent can switch between straight and
//   triplet sixteenths per note.
//
// Ports:
//   clk     in   clock
//   rstn    in   asynchronous active-low reset
//   i_en    in   count enable; the prescaler holds its value while low
//   i_clr   in   synchronous clear, takes priority over i_en
//   i_last  in   terminal count (tick length - 1)
//   o_tick  out  combinational strobe: this edge wraps the prescaler
//   o_pre   out  current prescaler value (used for the gap compare)
// -----------------------------------------------------------------------------
module bzmusic_tick_div
  import bzmusic_pkg::*;
#(
  parameter int PRE_W = $clog2(DEF_TICK_CYC)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [PRE_W-1:0] i_last,
  output logic             o_tick,
  output logic [PRE_W-1:0] o_pre
);

  logic [PRE_W-1:0] r_pre;
  logic             w_wrap;

  assign w_wrap = (r_pre == i_last);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours; = here would create order-dependent
  // simulation that no longer matches the synthesised flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= '0;
    end else if (i_clr) begin
      r_pre <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign o_tick = i_en && !i_clr && w_wrap;
  assign o_pre  = r_pre;

endmodule

// File: rtl/bzmusic_beat_cnt.sv
// -----------------------------------------------------------------------------
// bzmusic_beat_cnt
//   Note-duration timer for the buzzer music path. The music controller FSM
//   enables it for the current score address; after N sixteenth notes it
//   returns a one-cycle beat_finish so the controller advances. note_gate
//   drops GAP_CYC cycles before the end of each note (and during pauses) so
//   the tune PWM can leave an audible gap between repeated notes.
//
// Parameters:
//   TICK_CYC       clk cycles per sixteenth note (>= 2)
//   GAP_CYC        articulation gap in cycles, 0 disables (< TICK_CYC)
//   TRIP_TICK_CYC  cycles per triplet sixteenth (> GAP_CYC)
//
// Ports:
//   clk          in   clock
//   rstn         in   asynchronous active-low reset
//   en           in   count enable from the controller
//   srst_n       in   synchronous active-low clear, priority over en
//   len_code     in   note length code (3 bits, 4 with BZMUSIC_TRIPLET_EN)
//   beat_finish  out  registered one-cycle pulse at the end of the note
//   note_gate    out  registered, high while the note should sound
//
// Optional feature: define BZMUSIC_TRIPLET_EN to widen len_code to 4 bits;
// bit 3 latched at note start selects the triplet tick length.
// -----------------------------------------------------------------------------
module bzmusic_beat_cnt
  import bzmusic_pkg::*;
#(
  parameter int TICK_CYC      = DEF_TICK_CYC,
  parameter int GAP_CYC       = DEF_GAP_CYC,
  parameter int TRIP_TICK_CYC = DEF_TRIP_TICK_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       srst_n,
`ifdef BZMUSIC_TRIPLET_EN
  input  logic [3:0] len_code,
`else
  input  logic [2:0] len_code,
`endif
  output logic       beat_finish,
  output logic       note_gate
);

  // The prescaler is sized for the longer of the two tick lengths so its
  // width does not depend on which build is selected.
  localparam int MAX_TICK = (TRIP_TICK_CYC > TICK_CYC) ? TRIP_TICK_CYC : TICK_CYC;
  localparam int PRE_W    = $clog2(MAX_TICK);

  // The gap compare looks at the pre-edge prescaler value, so the threshold
  // is one below (tick - gap): new L >= N*tick - gap  <=>  old L >= N*tick -
  // gap - 1, and in the last sixteenth that reduces to a prescaler compare.
  // With GAP_CYC == 0 the threshold equals the terminal count, which only
  // coincides with the finish edge where the gate drops anyway.
  localparam logic [PRE_W-1:0] TICK_LAST    = PRE_W'(TICK_CYC - 1);
  localparam logic [PRE_W-1:0] TICK_GAP_THR = PRE_W'(TICK_CYC - GAP_CYC - 1);
`ifdef BZMUSIC_TRIPLET_EN
  localparam logic [PRE_W-1:0] TRIP_LAST    = PRE_W'(TRIP_TICK_CYC - 1);
  localparam logic [PRE_W-1:0] TRIP_GAP_THR = PRE_W'(TRIP_TICK_CYC - GAP_CYC - 1);
`endif

  beat_state_t      r_state;
  beat_state_t      w_state_nxt;
  logic [3:0]       r_six;
  logic [3:0]       w_six_nxt;
  // N-1 is stored rather than N: four bits cover N = 1..16, and the reset
  // value 0 is the required N = 1.
  logic [3:0]       r_last_six;
  logic [3:0]       w_last_six_nxt;
  logic             r_beat_finish;
  logic             w_beat_finish_nxt;
  logic             r_note_gate;
  logic             w_note_gate_nxt;

  logic [2:0]       w_len_idx;
  logic [3:0]       w_len_last;
  logic [PRE_W-1:0] w_last;
  logic [PRE_W-1:0] w_gap_thr;
  logic [PRE_W-1:0] w_pre;
  logic             w_tick;
  logic             w_gap_hit;
  logic             w_div_en;
  logic             w_div_clr;

`ifdef BZMUSIC_TRIPLET_EN
  logic             r_trip;
  logic             w_trip_nxt;

  assign w_len_idx = len_code[2:0];
  assign w_last    = r_trip ? TRIP_LAST    : TICK_LAST;
  assign w_gap_thr = r_trip ? TRIP_GAP_THR : TICK_GAP_THR;
`else
  assign w_len_idx = len_code;
  assign w_last    = TICK_LAST;
  assign w_gap_thr = TICK_GAP_THR;
`endif

  assign w_len_last = 4'(len_lut(w_len_idx) - 5'd1);

  // The prescaler only runs while a note is counting; outside RUN it is held
  // at zero so every note starts on a fresh sixteenth.
  assign w_div_en  = (r_state == ST_RUN) && en && srst_n;
  assign w_div_clr = !srst_n || (r_state != ST_RUN);

  bzmusic_tick_div #(
    .PRE_W (PRE_W)
  ) u_tick_div (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_div_en),
    .i_clr  (w_div_clr),
    .i_last (w_last),
    .o_tick (w_tick),
    .o_pre  (w_pre)
  );

  assign w_gap_hit = (r_six == r_last_six) && (w_pre >= w_gap_thr);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_six         <= '0;
      r_last_six    <= '0;
      r_beat_finish <= 1'b0;
      r_note_gate   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_six         <= w_six_nxt;
      r_last_six    <= w_last_six_nxt;
      r_beat_finish <= w_beat_finish_nxt;
      r_note_gate   <= w_note_gate_nxt;
    end
  end

`ifdef BZMUSIC_TRIPLET_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trip <= 1'b0;
    end else begin
      r_trip <= w_trip_nxt;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    w_state_nxt       = r_state;
    w_six_nxt         = r_six;
    w_last_six_nxt    = r_last_six;
    w_beat_finish_nxt = 1'b0;
    w_note_gate_nxt   = 1'b0;
`ifdef BZMUSIC_TRIPLET_EN
    w_trip_nxt        = r_trip;
`endif

    if (!srst_n) begin
      w_state_nxt    = ST_IDLE;
      w_six_nxt      = '0;
      w_last_six_nxt = '0;
`ifdef BZMUSIC_TRIPLET_EN
      w_trip_nxt     = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_state_nxt     = ST_RUN;
            w_six_nxt       = '0;
            w_last_six_nxt  = w_len_last;
            w_note_gate_nxt = 1'b1;
`ifdef BZMUSIC_TRIPLET_EN
            w_trip_nxt      = len_code[3];
`endif
          end
        end

        ST_RUN: begin
          // en low is a pause: counters hold and the gate stays low.
          if (en) begin
            w_note_gate_nxt = !w_gap_hit;
            if (w_tick) begin
              if (r_six == r_last_six) begin
                w_beat_finish_nxt = 1'b1;
                w_note_gate_nxt   = 1'b0;
                w_state_nxt       = ST_DONE;
              end else begin
                w_six_nxt = r_six + 4'd1;
              end
            end
          end
        end

        // Holds with both outputs low until the controller clears it.
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign beat_finish = r_beat_finish;
  assign note_gate   = r_note_gate;

endmodule

// File: tb/tb_bzmusic_beat_cnt.sv
// -----------------------------------------------------------------------------
// tb_bzmusic_beat_cnt
//   Self-checking bench for bzmusic_beat_cnt with TICK_CYC=10, GAP_CYC=2,
//   TRIP_TICK_CYC=7. A note-level model (elapsed cycles versus N*tick) predicts
//   both outputs every cycle; each directed scenario also checks hand-computed
//   gate-high counts and finish positions relative to the start edge E0.
//   Define BZMUSIC_TRIPLET_EN to add the triplet scenario.
// -----------------------------------------------------------------------------
module tb_bzmusic_beat_cnt;

  localparam int TICK = 10;
  localparam int GAP  = 2;
  localparam int TRIP = 7;
`ifdef BZMUSIC_TRIPLET_EN
  localparam int LW = 4;
`else
  localparam int LW = 3;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          srst_n;
  logic [LW-1:0] len_code;
  logic          beat_finish;
  logic          note_gate;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bzmusic_beat_cnt #(
    .TICK_CYC      (TICK),
    .GAP_CYC       (GAP),
    .TRIP_TICK_CYC (TRIP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .srst_n      (srst_n),
    .len_code    (len_code),
    .beat_finish (beat_finish),
    .note_gate   (note_gate)
  );

  // ---------------------------------------------------------------------------
  // Note-level model: a note lasts N*tick enabled cycles; the gate is high
  // while the elapsed count is below N*tick - GAP and the note is not paused.
  // ---------------------------------------------------------------------------
  function automatic int note_cycles(input logic [LW-1:0] c);
    int n;
    case (c[2:0])
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd3: n = 8;
      3'd4: n = 16;
      3'd5: n = 3;
      3'd6: n = 6;
      default: n = 12;
    endcase
`ifdef BZMUSIC_TRIPLET_EN
    if (c[LW-1]) return n * TRIP;
`endif
    return n * TICK;
  endfunction

  int   m_phase;   // 0 idle, 1 counting, 2 done
  int   m_el;
  int   m_total;
  logic m_fin;
  logic m_gate;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0;
      m_el    <= 0;
      m_total <= 0;
      m_fin   <= 1'b0;
      m_gate  <= 1'b0;
    end else if (!srst_n) begin
      m_phase <= 0;
      m_el    <= 0;
      m_fin   <= 1'b0;
      m_gate  <= 1'b0;
    end else begin
      m_fin  <= 1'b0;
      m_gate <= 1'b0;
      if (m_phase == 0) begin
        if (en) begin
          m_phase <= 1;
          m_el    <= 0;
          m_total <= note_cycles(len_code);
          m_gate  <= 1'b1;
        end
      end else if (m_phase == 1) begin
        if (en) begin
          m_el <= m_el + 1;
          if (m_el + 1 == m_total) begin
            m_fin   <= 1'b1;
            m_phase <= 2;
          end else begin
            m_gate <= (m_el + 1 < m_total - GAP);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: advance past the edge, then compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("model_finish", {31'd0, beat_finish}, {31'd0, m_fin});
    check("model_gate",   {31'd0, note_gate},   {31'd0, m_gate});
  endtask

  // Return to IDLE through the synchronous clear.
  task automatic clear();
    en     = 1'b0;
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
  endtask

  // Iteration k drives the inputs seen at edge E0+k and samples just after it.
  task automatic run_note(input string nm,
                          input logic [LW-1:0] code_a, input logic [LW-1:0] code_b,
                          input int chg_k, input int ps, input int pe,
                          input int abort_k, input int nk,
                          input int exp_gate, input int exp_fin_k, input int exp_fin_cnt);
    int gate_cnt = 0;
    int fin_cnt  = 0;
    int fin_k    = -1;
    for (int k = 0; k < nk; k++) begin
      srst_n   = (k == abort_k) ? 1'b0 : 1'b1;
      en       = (k >= ps && k < pe) ? 1'b0 : 1'b1;
      len_code = (k >= chg_k) ? code_b : code_a;
      tick();
      if (note_gate === 1'b1) gate_cnt++;
      if (beat_finish === 1'b1) begin
        fin_cnt++;
        if (fin_k < 0) fin_k = k;
      end
    end
    check({nm, "_gate_cycles"}, gate_cnt, exp_gate);
    check({nm, "_finish_at"},   fin_k,    exp_fin_k);
    check({nm, "_finish_cnt"},  fin_cnt,  exp_fin_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    rstn     = 1'b0;
    en       = 1'b0;
    srst_n   = 1'b1;
    len_code = '0;
    repeat (3) tick();
    check("reset_finish", {31'd0, beat_finish}, 32'd0);
    check("reset_gate",   {31'd0, note_gate},   32'd0);
    rstn = 1'b1;

    // Async reset mid-note: five cycles into a quarter note the gate is high.
    run_note("pre_rst", LW'(2), LW'(2), 999, 999, 999, -1, 5, 5, -1, 0);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_finish", {31'd0, beat_finish}, 32'd0);
    check("async_rst_gate",   {31'd0, note_gate},   32'd0);
    tick();
    tick();
    rstn   = 1'b1;
    srst_n = 1'b1;
    en     = 1'b0;
    repeat (5) tick();
    check("idle_after_rst_gate", {31'd0, note_gate}, 32'd0);

    // Quarter note, en held high through DONE: gate 38, finish at E0+40.
    run_note("quarter", LW'(2), LW'(2), 999, 999, 999, -1, 46, 38, 40, 1);
    check("done_gate",   {31'd0, note_gate},   32'd0);
    check("done_finish", {31'd0, beat_finish}, 32'd0);
    clear();

    // Sixteenth with a 5-cycle pause from E0+4: finish at E0+15, gate 8.
    run_note("pause", LW'(0), LW'(0), 999, 4, 9, -1, 20, 8, 15, 1);
    clear();

    // Abort a half note at E0+20: no finish, 20 gate cycles.
    run_note("abort", LW'(3), LW'(3), 999, 999, 999, 20, 21, 20, -1, 0);
    check("abort_gate", {31'd0, note_gate}, 32'd0);
    // Fresh dotted-half note straight away: finish at E0+120, gate 118.
    run_note("restart", LW'(7), LW'(7), 999, 999, 999, -1, 124, 118, 120, 1);
    clear();

    // Length code changes 0 -> 4 at E0+3 and is ignored.
    run_note("lenchg", LW'(0), LW'(4), 3, 999, 999, -1, 14, 8, 10, 1);
    clear();

`ifdef BZMUSIC_TRIPLET_EN
    // Triplet quarter (4 x 7 cycles): gate 26, finish at E0+28.
    run_note("triplet", 4'b1010, 4'b1010, 999, 999, 999, -1, 32, 26, 28, 1);
    clear();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
